// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// the operand forward-select encoding used by the D-stage operand muxes.
package pipe_pkg;

  typedef logic [2:0] fwd_t;

  localparam fwd_t FWD_RF   = 3'b000;  // register file read
  localparam fwd_t FWD_EALU = 3'b001;  // E-stage ALU result
  localparam fwd_t FWD_MALU = 3'b010;  // M-stage ALU result
  localparam fwd_t FWD_MMEM = 3'b011;  // M-stage load data
  localparam fwd_t FWD_LONG = 3'b100;  // multi-cycle unit result

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-field bundle between the pipeline datapath (master) and the
// hazard/forwarding controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int RN_W = 5
);
  import pipe_pkg::*;

  // Decode stage
  logic [RN_W-1:0]      d_rs;
  logic [RN_W-1:0]      d_rt;
  logic                 d_use_rs;
  logic                 d_use_rt;
  logic                 d_wreg;
  logic [RN_W-1:0]      d_rn;
  logic                 d_long;
  // Execute stage
  logic                 e_wreg;
  logic                 e_m2reg;
  logic [RN_W-1:0]      e_rn;
  // Memory stage
  logic                 m_wreg;
  logic                 m_m2reg;
  logic [RN_W-1:0]      m_rn;
  // Controller outputs
  logic                 wpcir;
  logic                 bubble;
  fwd_t                 fwda;
  fwd_t                 fwdb;
  logic                 long_busy;
  logic                 long_done;
  logic [RN_W-1:0]      long_rn;
  logic [2**RN_W-1:0]   pending;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt, d_wreg, d_rn, d_long,
           e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn,
    input  wpcir, bubble, fwda, fwdb, long_busy, long_done, long_rn, pending
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt, d_wreg, d_rn, d_long,
           e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn,
    output wpcir, bubble, fwda, fwdb, long_busy, long_done, long_rn, pending
  );

endinterface

// File: rtl/pipe_scoreboard.sv
// Occupancy tracker for the single non-pipelined multi-cycle unit:
// latency down-counter, busy flag, in-flight destination and the
// per-register pending vector.
module pipe_scoreboard #(
  parameter int RN_W     = 5,
  parameter int LONG_LAT = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                issue,
  input  logic [RN_W-1:0]     issue_rn,
  output logic                busy,
  output logic                done,
  output logic [RN_W-1:0]     long_rn,
  output logic [2**RN_W-1:0]  pending
);

  localparam int CNT_W = $clog2(LONG_LAT);
  localparam int NREG  = 2**RN_W;

  logic [CNT_W-1:0] cnt;
  logic [NREG-1:0]  pending_nxt;

  assign done = busy & (cnt == '0);

  // Next pending vector: retire the finishing op first, then mark the new
  // one, so a back-to-back issue to the same register keeps its bit set.
  always_comb begin
    // NOTE: default assignment first so no path leaves pending_nxt unassigned (no latch).
    pending_nxt = pending;
    if (done) begin
      pending_nxt[long_rn] = 1'b0;
    end
    if (issue && (issue_rn != '0)) begin
      pending_nxt[issue_rn] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Latency counter, busy flag and destination latch; reload only on issue.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: non-blocking assignments for all sequential state.
      cnt     <= '0;
      busy    <= 1'b0;
      long_rn <= '0;
    end else if (issue) begin
      cnt     <= CNT_W'(LONG_LAT - 1);
      busy    <= 1'b1;
      long_rn <= issue_rn;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Pending vector register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the whole vector is reset; a stale bit would stall D forever.
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline: load/use,
// long-op RAW/WAW and structural stalls, plus per-operand forward selects.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RN_W     = 5,
  parameter int LONG_LAT = 4
) (
  input  logic             clock,
  input  logic             resetn,
  pipe_hazard_ctrl_if.slave hz
);

  logic                stall;
  logic                issue;
  logic                sb_busy;
  logic                sb_done;
  logic [RN_W-1:0]     sb_rn;
  logic [2**RN_W-1:0]  sb_pending;
  logic                load_use;
  logic                raw_long;
  logic                waw_long;
  logic                struct_long;

  // Priority forward select for one source operand.
  function automatic fwd_t fwd_sel(
    input logic [RN_W-1:0] src,
    input logic            l_done,
    input logic [RN_W-1:0] l_rn,
    input logic            e_wreg,
    input logic            e_m2reg,
    input logic [RN_W-1:0] e_rn,
    input logic            m_wreg,
    input logic            m_m2reg,
    input logic [RN_W-1:0] m_rn
  );
    fwd_t sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (l_done && (l_rn == src))                         sel = FWD_LONG;
      else if (e_wreg && !e_m2reg && (e_rn == src))        sel = FWD_EALU;
      else if (m_wreg && !m_m2reg && (m_rn == src))        sel = FWD_MALU;
      else if (m_wreg &&  m_m2reg && (m_rn == src))        sel = FWD_MMEM;
    end
    return sel;
  endfunction

  pipe_scoreboard #(
    .RN_W     (RN_W),
    .LONG_LAT (LONG_LAT)
  ) u_scoreboard (
    .clock    (clock),
    .resetn   (resetn),
    .issue    (issue),
    .issue_rn (hz.d_rn),
    .busy     (sb_busy),
    .done     (sb_done),
    .long_rn  (sb_rn),
    .pending  (sb_pending)
  );

  // Stall causes; a source completing this cycle is forwarded, not stalled.
  always_comb begin
    load_use = hz.e_wreg && hz.e_m2reg && (hz.e_rn != '0) &&
               ((hz.d_use_rs && (hz.e_rn == hz.d_rs)) ||
                (hz.d_use_rt && (hz.e_rn == hz.d_rt)));
    raw_long = (hz.d_use_rs && sb_pending[hz.d_rs] &&
                !(sb_done && (sb_rn == hz.d_rs))) ||
               (hz.d_use_rt && sb_pending[hz.d_rt] &&
                !(sb_done && (sb_rn == hz.d_rt)));
    waw_long    = hz.d_wreg && (hz.d_rn != '0) && sb_pending[hz.d_rn];
    struct_long = hz.d_long && sb_busy && !sb_done;
    stall       = load_use || raw_long || waw_long || struct_long;
    issue       = hz.d_long && !stall;
  end

  assign hz.wpcir     = ~stall;
  assign hz.bubble    = stall;
  assign hz.long_busy = sb_busy;
  assign hz.long_done = sb_done;
  assign hz.long_rn   = sb_rn;
  assign hz.pending   = sb_pending;

  assign hz.fwda = fwd_sel(hz.d_rs, sb_done, sb_rn, hz.e_wreg, hz.e_m2reg,
                           hz.e_rn, hz.m_wreg, hz.m_m2reg, hz.m_rn);
  assign hz.fwdb = fwd_sel(hz.d_rt, sb_done, sb_rn, hz.e_wreg, hz.e_m2reg,
                           hz.e_rn, hz.m_wreg, hz.m_m2reg, hz.m_rn);

endmodule
